tile_query_arbiter: RTL
=======================

Name: tile_query_arbiter

Overview:
- Shares the single maze tile-lookup port between Pac-Man and the four ghosts.
- Once per game tick it runs an arbitration round. Each requester that was valid at the tick gets at most one lookup of its {xtile, ytile}, granted round-robin.
- Each lookup's 4x2-bit neighbour info is routed back to the requester that issued it.
- Sits between the character/ghost game logic and the maze block, and runs on the game clock.

Parameters:
- NREQ, 5, number of requesters (0=pacman, 1=blinky, 2=pinky, 3=inky, 4=clyde).
- TILE_W, 7, width of one tile coordinate.
- INFO_W, 8, tile info width (4 directions x 2 bits).
- LAT, 2, fixed maze lookup latency in cycles, >=1.

Ports:
- clk  in  1  game clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse that starts an arbitration round.
- req_valid  in  NREQ  per-requester lookup request.
- req_tile  in  NREQ*2*TILE_W  per-requester {xtile, ytile}; requester i occupies bits [i*14 +: 14].
- req_ready  out  NREQ  grant strobe; a handshake completes when req_valid[i] and req_ready[i] are high in the same cycle.
- lk_valid  out  1  lookup issued to the maze this cycle.
- lk_tile  out  2*TILE_W  tile presented to the maze.
- lk_info  in  INFO_W  maze result, valid exactly LAT cycles after the lk_valid cycle.
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe.
- rsp_info  out  INFO_W  registered tile info for the responding requester.
- busy  out  1  high while the FSM is not IDLE.
- round_done  out  1  one-cycle pulse when a round completes.
- overrun  out  1  sticky flag; tick arrived while busy.

Behaviour:
- Reset (rst low, async):
  - FSM to IDLE; mask, ptr, ID pipeline and in-flight count all zero.
  - All outputs 0.
  - In-flight lookups are discarded, and lk_info returning after reset deasserts is ignored.
- IDLE:
  - On tick, mask <= req_valid.
  - If req_valid==0, pulse round_done on the next cycle and stay IDLE.
  - Otherwise go to ARB.
- ARB, each cycle:
  - Eligible set = mask & req_valid.
  - Grant the first eligible index at or after ptr, searching with wrap-around.
  - In the grant cycle, combinationally: req_ready[g]=1, lk_valid=1, lk_tile=req_tile[g].
  - Registered effects: clear mask[g], ptr <= (g+1) mod NREQ, push g into the LAT-deep ID pipeline, increment the in-flight count.
  - A requester whose req_valid drops before its grant has its mask bit cleared with no response. It is not serviced again until the next round.
  - When the next-state mask is empty, go to DRAIN. The grant in that same cycle still issues.
  - Maximum one grant per cycle, so a full round is NREQ back-to-back grants.
- Response path:
  - lk_info is captured in the cycle LAT after its grant.
  - rsp_valid[id] and rsp_info assert on the next cycle, i.e. LAT+1 cycles after the grant. They hold for one cycle and then return to 0.
  - The in-flight count decrements when rsp_valid asserts.
- DRAIN:
  - When the in-flight count is zero and no response is pending, pulse round_done on the next cycle and return to IDLE.
  - Example, LAT=2 with all five requesters valid and tick at cycle 0: grants in cycles 1-5, responses in cycles 4-8, round_done in cycle 9.
- tick while busy is ignored, and overrun is set until reset. If tick and round_done coincide, the tick counts as overrun.
- ptr persists across rounds so grant order stays fair from round to round.
- Widths:
  - ptr and IDs are $clog2(NREQ) bits.
  - In-flight count is $clog2(LAT+2) bits and never exceeds LAT+1.
- req_tile is sampled only in the grant cycle. A requester may change it at any other time.

Decomposition:
- Shared package pacman_pkg:
  - requester index constants (REQ_PACMAN..REQ_CLYDE);
  - the tile-info direction field order (up, left, down, right; 2 bits each);
  - the FSM state enum {IDLE, ARB, DRAIN}.
- One sub-module, rr_pick: a combinational round-robin picker with inputs (eligible mask, ptr) and outputs (grant index, any).

Test Plan:
- Reset, then tick with req_valid=5'b11111, ptr=0, LAT=2:
  - grants go to 0,1,2,3,4 in cycles 1-5;
  - rsp_valid is one-hot 0..4 in cycles 4-8, with rsp_info equal to the model maze data for each tile;
  - round_done in cycle 9.
- Second round with req_valid=5'b10100 and ptr=0:
  - grant order 2 then 4; ptr ends at 0;
  - exactly two rsp_valid pulses; round_done 1 cycle after the last one.
- Round with ptr=3 and all valid → grant order 3,4,0,1,2.
- Requester 1 drops req_valid before its grant → no req_ready[1] and no rsp_valid[1]; the others complete; round_done still pulses.
- tick with req_valid=0 → round_done next cycle, busy stays 0. A tick during ARB → overrun=1 and the round result is unchanged.
- rst asserted mid-DRAIN with 2 lookups in flight:
  - all outputs go to 0 immediately;
  - no rsp_valid after release;
  - the next tick starts a clean round from ptr=0.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man game logic: requester indices, tile-info
// field layout and the tile-query arbiter state encoding.
package pacman_pkg;

    // Requester indices on the shared maze lookup port.
    localparam int unsigned REQ_PACMAN = 0;
    localparam int unsigned REQ_BLINKY = 1;
    localparam int unsigned REQ_PINKY  = 2;
    localparam int unsigned REQ_INKY   = 3;
    localparam int unsigned REQ_CLYDE  = 4;
    localparam int unsigned NUM_REQ    = 5;

    // Tile info carries one 2-bit field per direction; up sits in the low bits.
    localparam int unsigned DIR_FIELD_W = 2;
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Arbiter round states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Extract the 2-bit neighbour field for one direction from a tile-info word.
    function automatic logic [DIR_FIELD_W-1:0] tile_dir_field(input logic [7:0] info,
                                                              input dir_e       dir);
        return info[DIR_FIELD_W*int'(dir) +: DIR_FIELD_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of the eligible mask at or
// after ptr, searching with wrap-around.
module rr_pick #(
    parameter int unsigned NREQ = 5,
    parameter int unsigned IdW  = 3
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IdW-1:0]  ptr,
    output logic [IdW-1:0]  grant_idx,
    output logic            any
);

    logic [IdW-1:0] cand;

    // Walk the candidates in priority order starting at ptr; keep the first hit.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IdW'((32'(ptr) + i) % NREQ);
            if (!any && eligible[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/tile_query_arbiter.sv
// Shares the single maze tile-lookup port between Pac-Man and the ghosts.
// Each tick starts a round granting every requester valid at the tick at most
// one lookup, round-robin; results return LAT cycles later and are routed back
// to the issuing requester one cycle after capture.
module tile_query_arbiter
    import pacman_pkg::*;
#(
    parameter int unsigned NREQ   = 5,
    parameter int unsigned TILE_W = 7,
    parameter int unsigned INFO_W = 8,
    parameter int unsigned LAT    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*2*TILE_W-1:0] req_tile,
    output logic [NREQ-1:0]          req_ready,
    output logic                     lk_valid,
    output logic [2*TILE_W-1:0]      lk_tile,
    input  logic [INFO_W-1:0]        lk_info,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [INFO_W-1:0]        rsp_info,
    output logic                     busy,
    output logic                     round_done,
    output logic                     overrun
);

    localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = $clog2(LAT + 2);
    localparam int unsigned TW   = 2 * TILE_W;

    arb_state_e               state_q, state_d;
    logic [NREQ-1:0]          mask_q, mask_d;
    logic [IdW-1:0]           ptr_q, ptr_d;
    logic [LAT-1:0]           pipe_vld_q;
    logic [LAT-1:0][IdW-1:0]  pipe_id_q;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [NREQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [INFO_W-1:0]        rsp_info_q;
    logic                     done_q, done_d;
    logic                     overrun_q;

    logic [NREQ-1:0]          eligible;
    logic [IdW-1:0]           gnt_idx;
    logic                     gnt_any;
    logic                     grant;
    logic                     capture;

    // Requesters that dropped req_valid lose their slot for this round.
    assign eligible = mask_q & req_valid;
    assign grant    = (state_q == ARB) && gnt_any;
    assign capture  = pipe_vld_q[LAT-1];

    rr_pick #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_pick (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    // Round FSM next state, grant strobes and lookup port drive.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        req_ready = '0;
        lk_valid  = 1'b0;
        lk_tile   = '0;
        unique case (state_q)
            IDLE: begin
                // A tick landing on the round_done cycle is an overrun, not a new round.
                if (tick && !done_q) begin
                    mask_d = req_valid;
                    if (req_valid == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ARB;
                    end
                end
            end
            ARB: begin
                mask_d = eligible;
                if (grant) begin
                    mask_d[gnt_idx]    = 1'b0;
                    req_ready[gnt_idx] = 1'b1;
                    lk_valid           = 1'b1;
                    lk_tile            = req_tile[gnt_idx*TW +: TW];
                    ptr_d = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + IdW'(1);
                end
                if (mask_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == '0 && pipe_vld_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In-flight count rises on a grant and falls as each result is captured.
    always_comb begin
        cnt_d       = cnt_q + CntW'(grant) - CntW'(capture);
        rsp_valid_d = capture ? (NREQ'(1) << pipe_id_q[LAT-1]) : '0;
    end

    // Round state, pointer and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (tick && (state_q != IDLE || done_q)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Requester-ID pipeline matching the maze latency, then the response register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld_q  <= '0;
            pipe_id_q   <= '0;
            rsp_valid_q <= '0;
            rsp_info_q  <= '0;
        end else begin
            pipe_vld_q[0] <= grant;
            pipe_id_q[0]  <= gnt_idx;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_info_q  <= capture ? lk_info : '0;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_info   = rsp_info_q;
    assign busy       = (state_q != IDLE);
    assign round_done = done_q;
    assign overrun    = overrun_q;

endmodule
